// File: rtl/icache_mem_ctrl_if.sv
// Request/response and byte-wide RAM port bundle for icache_mem_ctrl.
// Requests are levels held until the matching done pulse; the RAM read data lags the address by one cycle.
interface icache_mem_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 16
);
  logic                     if_req;
  logic [ADDRESS_WIDTH-1:0] if_addr;
  logic                     if_done;
  logic [BLOCK_SIZE*8-1:0]  if_line;

  logic                     ls_req;
  logic                     ls_we;
  logic [ADDRESS_WIDTH-1:0] ls_addr;
  logic [1:0]               ls_size;
  logic [31:0]              ls_wdata;
  logic                     ls_done;
  logic [31:0]              ls_rdata;

  logic [7:0]               mem_din;
  logic [7:0]               mem_dout;
  logic [ADDRESS_WIDTH-1:0] mem_a;
  logic                     mem_wr;

  // Requesters and the RAM model sit on the master side.
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_size, ls_wdata, mem_din,
    input  if_done, if_line, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_size, ls_wdata, mem_din,
    output if_done, if_line, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/icache_mem_ctrl.sv
// Byte-serial RAM controller arbitrating icache refills and load/store accesses (round robin on ties).
// Read: done n+2 cycles after grant; write: done n+1 cycles after grant; requesters wait on the done pulse.
module icache_mem_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 16
) (
  input  logic             clk,
  input  logic             rst,
  icache_mem_ctrl_if.slave bus
);

  localparam int CW = $clog2(BLOCK_SIZE) + 1;
  localparam int LW = BLOCK_SIZE * 8;
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = ~ADDRESS_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    LS_RD,
    LS_WR,
    DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic                     grant_if;
  logic                     grant_ls;
  logic                     rd_end;
  logic                     last_grant;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            last_idx;
  logic [LW-1:0]            line_buf;
  logic [LW-1:0]            next_buf;
  logic [23:0]              wsh;
  logic [ADDRESS_WIDTH-1:0] mem_a_q;
  logic [7:0]               mem_dout_q;
  logic                     mem_wr_q;
  logic                     if_done_q;
  logic                     ls_done_q;
  logic [LW-1:0]            if_line_q;
  logic [31:0]              ls_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_ls = 1'b0;
    // cnt reaches n one cycle after the last address, when the final byte arrives.
    rd_end   = (cnt == last_idx + CW'(1));
    next_buf = line_buf;

    for (int k = 0; k < BLOCK_SIZE; k++) begin
      if (cnt != '0 && int'(cnt) == k + 1) begin
        next_buf[8*k +: 8] = bus.mem_din;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.if_req && bus.ls_req) begin
          grant_if = last_grant;
          grant_ls = !last_grant;
        end else begin
          grant_if = bus.if_req;
          grant_ls = bus.ls_req;
        end
        if (grant_if) begin
          state_d = IF_RD;
        end else if (grant_ls) begin
          state_d = bus.ls_we ? LS_WR : LS_RD;
        end
      end
      IF_RD, LS_RD: begin
        if (rd_end) begin
          state_d = DONE;
        end
      end
      LS_WR: begin
        if (cnt == last_idx) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
      cnt        <= '0;
      last_idx   <= '0;
      line_buf   <= '0;
      wsh        <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_line_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_if) begin
            last_grant <= 1'b0;
            cnt        <= '0;
            last_idx   <= CW'(BLOCK_SIZE - 1);
            line_buf   <= '0;
            mem_a_q    <= bus.if_addr & LINE_MASK;
          end else if (grant_ls) begin
            last_grant <= 1'b1;
            cnt        <= '0;
            line_buf   <= '0;
            mem_a_q    <= bus.ls_addr;
            case (bus.ls_size)
              2'd0:    last_idx <= CW'(0);
              2'd1:    last_idx <= CW'(1);
              default: last_idx <= CW'(3);
            endcase
            if (bus.ls_we) begin
              mem_wr_q   <= 1'b1;
              mem_dout_q <= bus.ls_wdata[7:0];
              wsh        <= bus.ls_wdata[31:8];
            end
          end
        end

        IF_RD, LS_RD: begin
          cnt      <= cnt + 1'b1;
          line_buf <= next_buf;
          if (cnt < last_idx) begin
            mem_a_q <= mem_a_q + 1'b1;
          end
          if (rd_end) begin
            mem_a_q <= '0;
            if (state_q == IF_RD) begin
              if_line_q <= next_buf;
              if_done_q <= 1'b1;
            end else begin
              ls_rdata_q <= next_buf[31:0];
              ls_done_q  <= 1'b1;
            end
          end
        end

        LS_WR: begin
          if (cnt == last_idx) begin
            mem_wr_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            ls_done_q  <= 1'b1;
          end else begin
            cnt        <= cnt + 1'b1;
            mem_a_q    <= mem_a_q + 1'b1;
            mem_dout_q <= wsh[7:0];
            wsh        <= {8'h00, wsh[23:8]};
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_line  = if_line_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_icache_mem_ctrl.sv
// Directed bench for icache_mem_ctrl: arbitration, refill, byte-serial load/store, wrap and reset abort.
module tb_icache_mem_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  logic [7:0] ram [0:4095];

  icache_mem_ctrl_if #(.ADDRESS_WIDTH(32), .BLOCK_SIZE(16)) bus ();

  icache_mem_ctrl #(.ADDRESS_WIDTH(32), .BLOCK_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: address sampled mid-cycle, data appears just after the next edge.
  initial begin
    logic [11:0] a;
    logic        wr;
    logic [7:0]  d;
    logic [7:0]  rd;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    for (int k = 0; k < 16; k++) ram[12'h100 + k] = 8'(k);
    ram[12'h010] = 8'h80;
    ram[12'h020] = 8'hA1;
    ram[12'h021] = 8'hB2;
    ram[12'h022] = 8'hC3;
    ram[12'h023] = 8'hD4;
    ram[12'hFFE] = 8'h11;
    ram[12'hFFF] = 8'h22;
    ram[12'h000] = 8'h33;
    ram[12'h001] = 8'h44;
    bus.mem_din = 8'h00;
    forever begin
      @(negedge clk);
      a  = bus.mem_a[11:0];
      wr = bus.mem_wr;
      d  = bus.mem_dout;
      @(posedge clk);
      #1;
      rd = ram[a];
      if (wr) ram[a] = d;
      bus.mem_din = rd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] wdat;
    int          hits;
    n_cmp = 0;
    n_mis = 0;

    // Both requesters high from reset: word load across the address wrap vs refill.
    rst          = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0104;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b0;
    bus.ls_size  = 2'd2;
    bus.ls_addr  = 32'hFFFF_FFFE;
    bus.ls_wdata = 32'h0;
    repeat (3) step();
    chk("rst_if_done",  bus.if_done,  1'b0);
    chk("rst_ls_done",  bus.ls_done,  1'b0);
    chk("rst_mem_wr",   bus.mem_wr,   1'b0);
    chk("rst_mem_a",    bus.mem_a,    32'h0);
    chk("rst_mem_dout", bus.mem_dout, 8'h0);
    chk("rst_if_line",  bus.if_line,  128'h0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
    rst = 1'b0;

    step(); chk("wrap_a1", bus.mem_a, 32'hFFFF_FFFE);
    chk("wrap_wr", bus.mem_wr, 1'b0);
    step(); chk("wrap_a2", bus.mem_a, 32'hFFFF_FFFF);
    step(); chk("wrap_a3", bus.mem_a, 32'h0000_0000);
    step(); chk("wrap_a4", bus.mem_a, 32'h0000_0001);
    step(); chk("wrap_hold_a", bus.mem_a, 32'h0000_0001);
    chk("wrap_done_early", bus.ls_done, 1'b0);
    step(); chk("wrap_done", bus.ls_done, 1'b1);
    chk("wrap_rdata", bus.ls_rdata, 32'h4433_2211);
    chk("wrap_if_idle", bus.if_done, 1'b0);
    bus.ls_req = 1'b0;

    // Refill of line 0x100 follows in the next IDLE cycle.
    step();
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("refill1_a%0d", k), bus.mem_a, 32'h100 + 32'(k - 1));
    end
    step(); chk("refill1_hold_a", bus.mem_a, 32'h0000_010F);
    chk("refill1_done_early", bus.if_done, 1'b0);
    step(); chk("refill1_done", bus.if_done, 1'b1);
    chk("refill1_line", bus.if_line, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("refill1_rdata_hold", bus.ls_rdata, 32'h4433_2211);
    bus.if_req = 1'b0;

    // Second tie (last grant IF): word store 0xDEADBEEF at 0x203 wins.
    step();
    wdat         = 32'hDEAD_BEEF;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0208;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_size  = 2'd2;
    bus.ls_addr  = 32'h0000_0203;
    bus.ls_wdata = wdat;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) bus.ls_wdata = 32'h0;
      chk($sformatf("st_wr%0d", k), bus.mem_wr, 1'b1);
      chk($sformatf("st_a%0d", k), bus.mem_a, 32'h203 + 32'(k - 1));
      chk($sformatf("st_d%0d", k), bus.mem_dout, wdat[8*(k-1) +: 8]);
    end
    step(); chk("st_done", bus.ls_done, 1'b1);
    chk("st_wr_off", bus.mem_wr, 1'b0);
    chk("st_a_off", bus.mem_a, 32'h0);
    // Load request kept high into the next IDLE: tie again, last grant LS, so IF wins.
    bus.ls_we   = 1'b0;
    bus.ls_addr = 32'h0000_0203;

    step();
    step(); chk("tie3_if_first", bus.mem_a, 32'h0000_0200);
    for (int k = 2; k <= 16; k++) step();
    chk("refill2_last_a", bus.mem_a, 32'h0000_020F);
    step();
    step(); chk("refill2_done", bus.if_done, 1'b1);
    chk("refill2_line", bus.if_line, 128'h000000000000000000DEADBEEF000000);
    bus.if_req = 1'b0;

    step();
    step(); chk("ld_a1", bus.mem_a, 32'h0000_0203);
    repeat (3) step();
    chk("ld_a4", bus.mem_a, 32'h0000_0206);
    step(); chk("ld_done_early", bus.ls_done, 1'b0);
    step(); chk("ld_done", bus.ls_done, 1'b1);
    chk("ld_rdata", bus.ls_rdata, 32'hDEAD_BEEF);
    bus.ls_req = 1'b0;

    // Byte load; address change after grant must be ignored.
    step();
    bus.ls_req  = 1'b1;
    bus.ls_size = 2'd0;
    bus.ls_addr = 32'h0000_0010;
    step(); chk("b_a1", bus.mem_a, 32'h0000_0010);
    bus.ls_addr = 32'h0000_0100;
    step(); chk("b_done_early", bus.ls_done, 1'b0);
    chk("b_rdata_hold", bus.ls_rdata, 32'hDEAD_BEEF);
    step(); chk("b_done", bus.ls_done, 1'b1);
    chk("b_rdata", bus.ls_rdata, 32'h0000_0080);
    bus.ls_req = 1'b0;

    // Size 3 loads a full word.
    step();
    bus.ls_req  = 1'b1;
    bus.ls_size = 2'd3;
    bus.ls_addr = 32'h0000_0020;
    repeat (4) step();
    chk("s3_a4", bus.mem_a, 32'h0000_0023);
    repeat (2) step();
    chk("s3_done", bus.ls_done, 1'b1);
    chk("s3_rdata", bus.ls_rdata, 32'hD4C3_B2A1);
    bus.ls_req = 1'b0;

    // Halfword load at an odd address.
    step();
    bus.ls_req  = 1'b1;
    bus.ls_size = 2'd1;
    bus.ls_addr = 32'h0000_0101;
    repeat (3) step();
    chk("h_done_early", bus.ls_done, 1'b0);
    step(); chk("h_done", bus.ls_done, 1'b1);
    chk("h_rdata", bus.ls_rdata, 32'h0000_0201);
    bus.ls_req = 1'b0;

    // Reset in cycle 8 of a refill aborts it.
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    repeat (8) step();
    chk("abort_a8", bus.mem_a, 32'h0000_0107);
    rst        = 1'b1;
    bus.if_req = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_mem_a", bus.mem_a, 32'h0);
    chk("abort_mem_wr", bus.mem_wr, 1'b0);
    chk("abort_if_done", bus.if_done, 1'b0);
    chk("abort_if_line", bus.if_line, 128'h0);
    chk("abort_ls_rdata", bus.ls_rdata, 32'h0);
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.if_done !== 1'b0) hits++;
    end
    chk("abort_no_done", hits, 0);

    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_010C;
    step(); chk("post_a1", bus.mem_a, 32'h0000_0100);
    repeat (16) step();
    chk("post_done_early", bus.if_done, 1'b0);
    step(); chk("post_done", bus.if_done, 1'b1);
    chk("post_line", bus.if_line, 128'h0F0E0D0C0B0A09080706050403020100);
    bus.if_req = 1'b0;
    step(); chk("post_pulse_end", bus.if_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
